// File: rtl/psg_write_decoder_if.sv
// Host-side bus of the SN76489 write port: data pins, /WE strobe, READY and the
// decoded register outputs that feed the tone, noise and attenuator blocks.
interface psg_write_decoder_if #(
  parameter int COUNTER_BITS = 10
);
  // Handshake: the host drops we_n with data_in already valid and holds data_in
  // for at least SYNC_STAGES+2 clocks. Only a falling edge seen while ready=1 is
  // a write; ready stays low for BUSY_CYCLES clocks after every accepted write.
  logic [7:0]              data_in;
  logic                    we_n;
  logic                    ready;
  logic [COUNTER_BITS-1:0] tone_freq_0;
  logic [COUNTER_BITS-1:0] tone_freq_1;
  logic [COUNTER_BITS-1:0] tone_freq_2;
  logic [3:0]              attenuation_0;
  logic [3:0]              attenuation_1;
  logic [3:0]              attenuation_2;
  logic [3:0]              attenuation_3;
  logic [2:0]              noise_control;
  logic                    restart_noise;

  modport master (
    output data_in, we_n,
    input  ready, tone_freq_0, tone_freq_1, tone_freq_2,
    input  attenuation_0, attenuation_1, attenuation_2, attenuation_3,
    input  noise_control, restart_noise
  );

  modport slave (
    input  data_in, we_n,
    output ready, tone_freq_0, tone_freq_1, tone_freq_2,
    output attenuation_0, attenuation_1, attenuation_2, attenuation_3,
    output noise_control, restart_noise
  );
endinterface

// File: rtl/psg_write_decoder.sv
// SN76489 write decoder: synchronises /WE, decodes latch/data bytes into tone
// periods, attenuations and noise control, and paces the host with READY.
module psg_write_decoder #(
  parameter int COUNTER_BITS = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  psg_write_decoder_if.slave  bus
);
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    edge_q;
  logic                    we_sync;
  logic                    write_det;
  logic                    accept;

  logic [COUNTER_BITS-1:0] tone_q [0:2];
  logic [COUNTER_BITS-1:0] tone_d [0:2];
  logic [3:0]              att_q  [0:3];
  logic [3:0]              att_d  [0:3];
  logic [2:0]              noise_q, noise_d;
  logic [2:0]              addr_q, addr_d;
  logic                    restart_q, restart_d;
  logic [BW-1:0]           busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic [2:0]              sel;
  logic [1:0]              ch;

  assign we_sync   = sync_q[SYNC_STAGES-1];
  assign write_det = edge_q & ~we_sync;
  assign accept    = write_det & ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.we_n};
      edge_q <= we_sync;
    end
  end

  // A latch byte carries its own address; a data byte reuses the held one.
  always_comb begin
    tone_d    = tone_q;
    att_d     = att_q;
    noise_d   = noise_q;
    addr_d    = addr_q;
    restart_d = 1'b0;
    busy_d    = busy_q;
    sel       = bus.data_in[7] ? bus.data_in[6:4] : addr_q;
    ch        = sel[2:1];
    if (busy_q != '0) busy_d = busy_q - 1'b1;
    if (accept) begin
      busy_d = BUSY_LOAD;
      if (bus.data_in[7]) addr_d = bus.data_in[6:4];
      if (sel[0]) begin
        att_d[ch] = bus.data_in[3:0];
      end else if (ch == 2'd3) begin
        noise_d   = bus.data_in[2:0];
        restart_d = 1'b1;
      end else if (bus.data_in[7]) begin
        tone_d[ch][3:0] = bus.data_in[3:0];
      end else begin
        tone_d[ch][COUNTER_BITS-1:4] = bus.data_in[5:0];
      end
    end
    ready_d = (busy_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q    <= '{default: '0};
      att_q     <= '{default: 4'hF};
      noise_q   <= 3'b000;
      addr_q    <= 3'b000;
      restart_q <= 1'b0;
      busy_q    <= '0;
      ready_q   <= 1'b1;
    end else begin
      tone_q    <= tone_d;
      att_q     <= att_d;
      noise_q   <= noise_d;
      addr_q    <= addr_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.tone_freq_0   = tone_q[0];
  assign bus.tone_freq_1   = tone_q[1];
  assign bus.tone_freq_2   = tone_q[2];
  assign bus.attenuation_0 = att_q[0];
  assign bus.attenuation_1 = att_q[1];
  assign bus.attenuation_2 = att_q[2];
  assign bus.attenuation_3 = att_q[3];
  assign bus.noise_control = noise_q;
  assign bus.restart_noise = restart_q;
endmodule

// File: tb/tb_psg_write_decoder.sv
// Self-checking bench for psg_write_decoder: directed scenarios plus random byte
// streams compared every cycle against a register-level model of the PSG.
module tb_psg_write_decoder;
  localparam int SYNC = 2;
  localparam int BUSY = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psg_write_decoder_if #(.COUNTER_BITS(10)) bus ();

  psg_write_decoder #(
    .COUNTER_BITS(10),
    .SYNC_STAGES (SYNC),
    .BUSY_CYCLES (BUSY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ready edge observer
  logic prev_rdy = 1'b1;
  int   rdy_falls = 0;
  int   rdy_fall_cyc = 0;
  int   rdy_rise_cyc = 0;
  always @(negedge clk) begin
    if (prev_rdy && !bus.ready) begin rdy_falls++; rdy_fall_cyc = cyc; end
    if (!prev_rdy && bus.ready) rdy_rise_cyc = cyc;
    prev_rdy = bus.ready;
  end

  // ---------------- reference model ----------------
  logic [9:0] tone_m [3];
  logic [3:0] att_m  [4];
  logic [2:0] noise_m;
  logic [2:0] addr_m;
  int         ready_at;     // first cycle index in which ready is high again
  int         restart_cyc;  // cycle index in which the restart pulse is visible
  bit         pending;
  int         fall_cyc;
  logic [7:0] fall_d;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) tone_m[i] = '0;
    for (int i = 0; i < 4; i++) att_m[i] = 4'hF;
    noise_m     = '0;
    addr_m      = '0;
    ready_at    = 0;
    restart_cyc = -1;
    pending     = 0;
  endtask

  task automatic model_write(input logic [7:0] d);
    int target;
    int chn;
    target = d[7] ? int'(d[6:4]) : int'(addr_m);
    addr_m = 3'(target);
    chn    = target / 2;
    if (target % 2 == 1)   att_m[chn] = 4'(int'(d) % 16);
    else if (chn == 3)     noise_m = 3'(int'(d) % 8);
    else if (d[7])         tone_m[chn] = 10'((int'(tone_m[chn]) / 16) * 16 + int'(d) % 16);
    else                   tone_m[chn] = 10'((int'(d) % 64) * 16 + int'(tone_m[chn]) % 16);
  endtask

  function automatic logic [51:0] model_vec();
    return {tone_m[0], tone_m[1], tone_m[2], att_m[0], att_m[1], att_m[2], att_m[3],
            noise_m, 1'(cyc >= ready_at), 1'(cyc == restart_cyc)};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {bus.tone_freq_0, bus.tone_freq_1, bus.tone_freq_2,
            bus.attenuation_0, bus.attenuation_1, bus.attenuation_2, bus.attenuation_3,
            bus.noise_control, bus.ready, bus.restart_noise};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge and let the model retire a detected write.
  task automatic step();
    @(negedge clk);
    if (pending && cyc == fall_cyc + SYNC + 1) begin
      pending = 0;
      if (cyc - 1 >= ready_at) begin
        model_write(fall_d);
        ready_at = cyc + BUSY;
        if (addr_m == 3'b110) restart_cyc = cyc;
      end
    end
  endtask

  task automatic fall(input logic [7:0] d);
    step();
    bus.data_in = d;
    bus.we_n    = 1'b0;
    fall_cyc    = cyc;
    fall_d      = d;
    pending     = 1;
  endtask

  task automatic rise();
    step();
    bus.we_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (cyc < ready_at || pending); i++) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL reset_hold got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_tone();
    logic [7:0] seq [2] = '{8'h8E, 8'h0F};
    for (int w = 0; w < 2; w++) begin
      wait_idle();
      fall(seq[w]);
      for (int i = 0; i < 6; i++) begin
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++; $display("FAIL tone_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        end
      end
      rise();
    end
    checks++;
    if (bus.tone_freq_0 !== 10'h0FE) begin
      failures++; $display("FAIL tone0_value got=%h exp=%h", bus.tone_freq_0, 10'h0FE);
    end
  endtask

  task automatic test_atten();
    logic [7:0] seq [2] = '{8'hD5, 8'h03};
    logic [3:0] want [2] = '{4'h5, 4'h3};
    logic [9:0] tone2_before;
    tone2_before = bus.tone_freq_2;
    for (int w = 0; w < 2; w++) begin
      wait_idle();
      fall(seq[w]);
      for (int i = 0; i < 6; i++) begin
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++; $display("FAIL atten_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        end
      end
      rise();
      checks++;
      if (bus.attenuation_2 !== want[w]) begin
        failures++; $display("FAIL atten2_value got=%h exp=%h", bus.attenuation_2, want[w]);
      end
    end
    checks++;
    if (bus.tone_freq_2 !== tone2_before) begin
      failures++; $display("FAIL atten_no_tone got=%h exp=%h", bus.tone_freq_2, tone2_before);
    end
  endtask

  task automatic test_noise();
    logic [7:0] seq [2] = '{8'hE4, 8'h07};
    logic [2:0] want [2] = '{3'b100, 3'b111};
    int pulses;
    for (int w = 0; w < 2; w++) begin
      wait_idle();
      pulses = 0;
      fall(seq[w]);
      for (int i = 0; i < 8; i++) begin
        step();
        if (bus.restart_noise === 1'b1) pulses++;
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++; $display("FAIL noise_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        end
      end
      rise();
      checks++;
      if (pulses != 1) begin
        failures++; $display("FAIL noise_pulses got=%0d exp=1", pulses);
      end
      checks++;
      if (bus.noise_control !== want[w]) begin
        failures++; $display("FAIL noise_value got=%b exp=%b", bus.noise_control, want[w]);
      end
    end
  endtask

  task automatic test_busy_drop();
    int f0;
    int first_fall;
    wait_idle();
    f0 = rdy_falls;
    fall(8'hA2);
    first_fall = fall_cyc;
    repeat (4) step();
    rise();
    while (cyc < first_fall + SYNC + 1 + 10) step();
    fall(8'hAD);
    repeat (4) step();
    rise();
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL busy_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    checks++;
    if (rdy_falls - f0 != 1) begin
      failures++; $display("FAIL busy_windows got=%0d exp=1", rdy_falls - f0);
    end
    checks++;
    if (rdy_rise_cyc - rdy_fall_cyc != BUSY) begin
      failures++; $display("FAIL busy_length got=%0d exp=%0d", rdy_rise_cyc - rdy_fall_cyc, BUSY);
    end
    checks++;
    if (bus.tone_freq_1[3:0] !== 4'h2) begin
      failures++; $display("FAIL busy_drop_value got=%h exp=%h", bus.tone_freq_1[3:0], 4'h2);
    end
  endtask

  task automatic test_edge_only();
    int f0;
    int lat;
    wait_idle();
    f0  = rdy_falls;
    lat = -1;
    fall(8'hB7);
    for (int i = 0; i < 100; i++) begin
      step();
      if (lat < 0 && bus.attenuation_1 === 4'h7) lat = cyc - fall_cyc;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL edge_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    rise();
    checks++;
    if (rdy_falls - f0 != 1) begin
      failures++; $display("FAIL edge_windows got=%0d exp=1", rdy_falls - f0);
    end
    checks++;
    if (lat != SYNC + 1) begin
      failures++; $display("FAIL edge_latency got=%0d exp=%0d", lat, SYNC + 1);
    end
  endtask

  task automatic test_random();
    int hold;
    int gap;
    for (int n = 0; n < 40; n++) begin
      fall(8'($urandom_range(0, 255)));
      hold = $urandom_range(SYNC + 2, 8);
      for (int i = 0; i < hold; i++) begin
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        end
      end
      rise();
      gap = $urandom_range(3, 40);
      for (int i = 0; i < gap; i++) begin
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
          failures++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    wait_idle();
    fall(8'h9A);
    repeat (4) step();
    rise();
    repeat (10) step();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++; $display("FAIL midbusy_precond got=%b exp=0", bus.ready);
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL post_reset got=%h exp=%h", dut_vec(), model_vec());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.we_n    = 1'b1;
    bus.data_in = 8'h00;
    rst_n       = 1'b0;
    model_reset();
    test_reset();
    test_tone();
    test_atten();
    test_noise();
    test_busy_drop();
    test_edge_only();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
